hamming74_stream_decoder: RTL and testbench
===========================================

HAMMING74_STREAM_DECODER -- requirements
Module: hamming74_stream_decoder

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of each statistics counter (legal range 4..32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_code holds a valid codeword.
REQ-005 in_ready  output  1  block accepts in_code this cycle.
REQ-006 in_code  input  7  Hamming(7,4) codeword: [6:3]=d3..d0, [2]=d3^d2^d1, [1]=d3^d2^d0, [0]=d3^d1^d0.
REQ-007 out_valid  output  1  out_data, out_corr and out_syn are valid.
REQ-008 out_ready  input  1  downstream accepts output this cycle.
REQ-009 out_data  output  4  corrected data d3..d0.
REQ-010 out_corr  output  1  the word had a nonzero syndrome and one bit was flipped.
REQ-011 out_syn  output  3  raw syndrome {s2,s1,s0}.
REQ-012 cnt_clr  input  1  synchronous clear of both counters.
REQ-013 word_cnt  output  CNT_W  words delivered on the output.
REQ-014 corr_cnt  output  CNT_W  delivered words with out_corr=1.

Function
REQ-015 Syndrome SHALL be s2=c6^c5^c4^c2, s1=c6^c5^c3^c1, s0=c6^c4^c3^c0.
REQ-016 Syndrome-to-bit map SHALL be 111->c6, 110->c5, 101->c4, 011->c3, 100->c2, 010->c1, 001->c0, 000->none; the mapped bit is inverted before extracting out_data=c[6:3].
REQ-017 out_corr SHALL be 1 iff syndrome != 000, including when only a parity bit is flipped.
REQ-018 Pipeline SHALL have two register stages: S1 holds the codeword and syndrome, S2 holds the corrected data, out_corr and out_syn.
REQ-019 Input transfer occurs when in_valid&&in_ready; output transfer occurs when out_valid&&out_ready.
REQ-020 A stage SHALL advance when it is empty or its successor advances in the same cycle; in_ready = !S1_valid || S1 advances; out_valid = S2_valid.
REQ-021 With out_ready held at 1, latency SHALL be 2 cycles from input transfer to out_valid and throughput 1 word/cycle.
REQ-022 With out_ready=0 and both stages full, in_ready SHALL be 0; payload and out_valid SHALL hold stable until transfer; no word is lost or duplicated.
REQ-023 in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 Counters SHALL increment on output transfer (corr_cnt only when out_corr=1) and saturate at all-ones.
REQ-025 cnt_clr SHALL zero both counters on the next edge and take priority over a simultaneous increment.
REQ-026 Double-bit errors are out of scope: they SHALL be miscorrected per REQ-016 with out_corr=1 and no extra flag.

Reset
REQ-027 rst_n low SHALL asynchronously clear S1_valid, S2_valid, out_data, out_corr, out_syn, word_cnt and corr_cnt to 0; in_ready SHALL read 1 while reset is released.
REQ-028 Reset mid-stream SHALL discard all in-flight words; the first transfer after release starts a clean pipeline.

Configuration
REQ-029 Macro HAMMING_DEC_STATS_EN: when defined, counters behave per REQ-024/025.
REQ-030 When HAMMING_DEC_STATS_EN is undefined, word_cnt and corr_cnt SHALL be constant 0, cnt_clr SHALL be ignored, no counter flops are present, and ports remain unchanged.

Verification
REQ-031 in_code=7'h59, out_ready=1 -> 2 cycles later out_data=4'b1011, out_corr=0, out_syn=3'b000.
REQ-032 in_code=7'h79 (c5 flipped from 7'h59) -> out_data=4'b1011, out_corr=1, out_syn=3'b110; corr_cnt +1.
REQ-033 All 16 data values x 8 patterns (none or one of the 7 bits flipped), out_ready random -> data always corrected, order preserved, word_cnt=128, corr_cnt=112.
REQ-034 Fill the pipeline with out_ready=0 -> in_ready=0 after 2 accepts, output stable; release -> words emerge in order, none lost.
REQ-035 CNT_W=4, 20 corrected words -> counters saturate at 15; cnt_clr together with a transfer -> both 0.
REQ-036 rst_n pulsed low with both stages full -> out_valid=0 immediately, counters 0; HAMMING_DEC_STATS_EN undefined -> counters read 0 throughout.

Source files
------------

// File: rtl/hamming74_stream_decoder.sv
// Two-stage valid/ready Hamming(7,4) single-error-correcting decoder with optional delivery statistics.
// Statistics counters exist only when HAMMING_DEC_STATS_EN is defined; otherwise they read 0.
module hamming74_stream_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_corr,
  output logic [2:0]       out_syn,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] corr_cnt
);

  logic       s1_valid;
  logic       s2_valid;
  logic [6:0] s1_code;
  logic [2:0] s1_syn;
  logic [2:0] in_syn;
  logic [6:0] flip_mask;
  logic [6:0] fixed_code;
  logic       s1_adv;
  logic       s2_adv;

  // Ready is derived purely from pipeline occupancy and out_ready, never from in_valid.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  assign in_syn = {in_code[6] ^ in_code[5] ^ in_code[4] ^ in_code[2],
                   in_code[6] ^ in_code[5] ^ in_code[3] ^ in_code[1],
                   in_code[6] ^ in_code[4] ^ in_code[3] ^ in_code[0]};

  always_comb begin
    flip_mask = 7'b0;
    case (s1_syn)
      3'b111:  flip_mask = 7'b100_0000;
      3'b110:  flip_mask = 7'b010_0000;
      3'b101:  flip_mask = 7'b001_0000;
      3'b011:  flip_mask = 7'b000_1000;
      3'b100:  flip_mask = 7'b000_0100;
      3'b010:  flip_mask = 7'b000_0010;
      3'b001:  flip_mask = 7'b000_0001;
      default: flip_mask = 7'b0;
    endcase
  end

  assign fixed_code = s1_code ^ flip_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= 7'b0;
      s1_syn   <= 3'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code;
        s1_syn  <= in_syn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= 4'b0;
      out_corr <= 1'b0;
      out_syn  <= 3'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= fixed_code[6:3];
        out_corr <= (s1_syn != 3'b000);
        out_syn  <= s1_syn;
      end
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  logic out_xfer;
  assign out_xfer = out_valid && out_ready;

  // Clear wins over a coincident delivery; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      corr_cnt <= '0;
    end else if (cnt_clr) begin
      word_cnt <= '0;
      corr_cnt <= '0;
    end else if (out_xfer) begin
      if (word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
      if (out_corr && (corr_cnt != '1)) corr_cnt <= corr_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign word_cnt = '0;
  assign corr_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming74_stream_decoder.sv
// Scoreboard bench for hamming74_stream_decoder; counter expectations follow HAMMING_DEC_STATS_EN.
module tb_hamming74_stream_decoder;

`ifdef HAMMING_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_corr, cnt_clr;
  logic [6:0]  in_code;
  logic [3:0]  out_data;
  logic [2:0]  out_syn;
  logic [15:0] word_cnt, corr_cnt;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_corr4, cnt_clr4;
  logic [6:0]  in_code4;
  logic [3:0]  out_data4;
  logic [2:0]  out_syn4;
  logic [3:0]  word_cnt4, corr_cnt4;

  hamming74_stream_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_corr(out_corr),
    .out_syn(out_syn), .cnt_clr(cnt_clr), .word_cnt(word_cnt), .corr_cnt(corr_cnt));

  hamming74_stream_decoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_code(in_code4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_corr(out_corr4),
    .out_syn(out_syn4), .cnt_clr(cnt_clr4), .word_cnt(word_cnt4), .corr_cnt(corr_cnt4));

  int n_checks = 0;
  int n_errors = 0;
  int m_words  = 0;
  int m_corr   = 0;
  bit rnd_ready = 1'b0;
  logic [7:0] cur_exp;   // {data, corr, syn}
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] code_of(input logic [3:0] d);
    return {d, d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
  endfunction

  function automatic logic [2:0] syn_of_bit(input int b);
    case (b)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b100;
      3: return 3'b011;
      4: return 3'b101;
      5: return 3'b110;
      6: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Scoreboard: push on accepted input, pop/compare on delivered output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", exp_q.size(), 1);
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("out_word", {out_data, out_corr, out_syn}, e);
          m_words++;
          if (e[3]) m_corr++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  task automatic present(input logic [3:0] d, input int p);
    logic [6:0] mask;
    mask = (p == 0) ? 7'b0 : (7'b1 << (p - 1));
    in_code  = code_of(d) ^ mask;
    cur_exp  = {d, (p != 0), (p == 0) ? 3'b000 : syn_of_bit(p - 1)};
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit acc = 1'b0;
    int guard = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      guard++;
    end while (!acc && guard < 200);
    in_valid = 1'b0;
    check("send_accept", acc, 1);
  endtask

  task automatic send(input logic [3:0] d, input int p);
    present(d, p);
    wait_accept();
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_code = 7'h0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_valid4 = 1'b0; in_code4 = 7'h0; out_ready4 = 1'b1; cnt_clr4 = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", {out_data, out_corr, out_syn}, 0);
    check("rst_word_cnt", word_cnt, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean word: latency of two edges after transfer
    send(4'b1011, 0);
    check("lat_cyc1_valid", out_valid, 0);
    @(posedge clk); #1;
    check("lat_cyc2_valid", out_valid, 1);
    check("clean_data", out_data, 4'b1011);
    check("clean_syn", {out_corr, out_syn}, 4'b0000);
    drain();

    // c5 flipped: 7'h59 -> 7'h79
    send(4'b1011, 6);
    check("c5_code", in_code, 7'h79);
    drain();
    check("word_cnt_2", word_cnt, STATS ? 2 : 0);
    check("corr_cnt_1", corr_cnt, STATS ? 1 : 0);

    // Clear with empty pipeline, then 16 x 8 exhaustive single-error sweep with random backpressure
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clr_word_cnt", word_cnt, 0);
    m_words = 0; m_corr = 0;
    rnd_ready = 1'b1;
    for (int d = 0; d < 16; d++)
      for (int p = 0; p < 8; p++)
        send(4'(d), p);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain();
    check("sweep_words_model", m_words, 128);
    check("word_cnt_128", word_cnt, STATS ? 128 : 0);
    check("corr_cnt_112", corr_cnt, STATS ? 112 : 0);

    // Backpressure: two accepts fill the pipe, third word stalls, output holds
    out_ready = 1'b0;
    send(4'h3, 0);
    send(4'hC, 2);
    present(4'h5, 7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_word", {out_data, out_corr, out_syn}, 8'h30);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(4'h9, 1);
    send(4'h6, 4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_word_cnt", word_cnt, 0);
    check("midrst_corr_cnt", corr_cnt, 0);
    exp_q.delete();
    m_words = 0; m_corr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("postrst_out_valid", out_valid, 0);
    send(4'b1011, 0);
    drain();
    check("postrst_word_cnt", word_cnt, STATS ? 1 : 0);

    // CNT_W=4 instance: 20 corrected words saturate at 15
    in_code4 = 7'h58;
    in_valid4 = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sat_word_cnt4", word_cnt4, STATS ? 15 : 0);
    check("sat_corr_cnt4", corr_cnt4, STATS ? 15 : 0);
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    check("clr_xfer_valid4", out_valid4, 1);
    check("clr_xfer_data4", {out_data4, out_corr4, out_syn4}, 8'hB9);
    cnt_clr4 = 1'b1;
    @(posedge clk); #1;
    cnt_clr4 = 1'b0;
    check("clr_xfer_word4", word_cnt4, 0);
    check("clr_xfer_corr4", corr_cnt4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
